// File: rtl/lcd_char_queue_pkg.sv
// Shared definitions for the LCD character queue: drain FSM states, the
// HD44780 power-up sequence, and bit positions of the custom-instruction words.
package lcd_char_queue_pkg;

    typedef enum logic [1:0] {
        S_INIT_ISSUE = 2'd0,
        S_INIT_WAIT  = 2'd1,
        S_IDLE       = 2'd2,
        S_WAIT       = 2'd3
    } state_t;

    localparam int INIT_LEN = 4;

    localparam int DA_RS     = 0;
    localparam int DA_STATUS = 8;
    localparam int DA_FLUSH  = 9;

    localparam int RES_ACC  = 0;
    localparam int RES_CNT  = 8;
    localparam int RES_BUSY = 16;
    localparam int RES_INIT = 17;

    // 8-bit bus / 2 lines, display on, clear, entry mode increment
    function automatic logic [7:0] init_rom(input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = 8'h38;
            2'd1:    b = 8'h0C;
            2'd2:    b = 8'h01;
            default: b = 8'h06;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lcd_byte_fifo.sv
// Circular FIFO of {rs, byte} entries with push/pop/flush and an occupancy count.
// Head entry is presented combinationally on rdata whenever the FIFO is non-empty.
module lcd_byte_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clk_en,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];
    assign do_push = clk_en & push & ~full & ~flush;
    assign do_pop  = clk_en & pop & ~empty & ~flush;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Flush drops everything queued but keeps the write pointer where it is
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clk_en) begin
            if (flush) begin
                rd_ptr <= wr_ptr;
                count  <= '0;
            end else begin
                if (do_push) wr_ptr <= wr_ptr + AW'(1);
                if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
                case ({do_push, do_pop})
                    2'b10:   count <= count + (AW+1)'(1);
                    2'b01:   count <= count - (AW+1)'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: rtl/lcd_char_queue.sv
// Nios II custom-instruction front end that queues LCD bytes and drains them,
// after the HD44780 init sequence, into the byte-level driver one at a time.
module lcd_char_queue
    import lcd_char_queue_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int INIT_EN = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    input  logic [31:0] datab,
    output logic [31:0] result,
    output logic        done,
    output logic        drv_start,
    output logic        drv_rs,
    output logic [7:0]  drv_db,
    input  logic        drv_done
);

    state_t      state;
    logic [1:0]  init_idx;
    logic        init_done;
    logic        acc;

    logic        ci_fire;
    logic        is_flush;
    logic        is_status;
    logic        push;
    logic        flush_req;
    logic        pop;
    logic        busy;
    logic        unused_bits;

    logic [8:0]  fifo_rdata;
    logic [AW:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    assign ci_fire     = clk_en & start;
    assign is_flush    = dataa[DA_FLUSH];
    assign is_status   = dataa[DA_STATUS];
    assign push        = ci_fire & ~is_flush & ~is_status;
    assign flush_req   = ci_fire & is_flush;
    assign pop         = (state == S_IDLE) & ~fifo_empty;
    assign busy        = (state != S_IDLE) || (fifo_count != '0);
    assign unused_bits = ^{dataa[31:10], dataa[7:1], datab[31:8]};

    lcd_byte_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (9)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clk_en  (clk_en),
        .push    (push),
        .pop     (pop),
        .flush   (flush_req),
        .wdata   ({dataa[DA_RS], datab[7:0]}),
        .rdata   (fifo_rdata),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Result is only meaningful alongside done; count/busy reflect the state after the op
    always_comb begin
        result = '0;
        if (done) begin
            result[RES_ACC]           = acc;
            result[RES_CNT +: AW+1]   = fifo_count;
            result[RES_BUSY]          = busy;
            result[RES_INIT]          = init_done;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= (INIT_EN != 0) ? S_INIT_ISSUE : S_IDLE;
            init_idx  <= '0;
            init_done <= 1'b0;
            drv_start <= 1'b0;
            drv_rs    <= 1'b0;
            drv_db    <= '0;
            done      <= 1'b0;
            acc       <= 1'b0;
        end else if (clk_en) begin
            done      <= ci_fire;
            acc       <= push & ~fifo_full;
            drv_start <= 1'b0;
            case (state)
                S_INIT_ISSUE: begin
                    drv_rs    <= 1'b0;
                    drv_db    <= init_rom(init_idx);
                    drv_start <= 1'b1;
                    state     <= S_INIT_WAIT;
                end
                S_INIT_WAIT: begin
                    if (drv_done) begin
                        if (init_idx == 2'(INIT_LEN-1)) begin
                            init_done <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            init_idx <= init_idx + 2'd1;
                            state    <= S_INIT_ISSUE;
                        end
                    end
                end
                S_IDLE: begin
                    if (INIT_EN == 0) init_done <= 1'b1;
                    // Head is taken even if a flush lands this cycle; it becomes the in-flight byte
                    if (!fifo_empty) begin
                        drv_rs    <= fifo_rdata[8];
                        drv_db    <= fifo_rdata[7:0];
                        drv_start <= 1'b1;
                        state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (drv_done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_char_queue.sv
// Scoreboard bench for lcd_char_queue with a behavioural byte driver whose
// done pulse follows drv_start by about 20 cycles.
module tb_lcd_char_queue;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic [31:0] datab = '0;
    logic [31:0] result;
    logic        done;
    logic        drv_start;
    logic        drv_rs;
    logic [7:0]  drv_db;
    logic        drv_done;

    typedef struct {
        logic        acc;
        logic [AW:0] cnt;
        logic        busy;
        logic        init;
    } ci_exp_t;

    ci_exp_t    ci_q[$];
    logic [8:0] drv_q[$];
    ci_exp_t    ci_e;
    logic [8:0] drv_e;
    int         passed = 0;
    int         total  = 0;
    int         dd_cnt = 0;
    int         tmr;
    int         base;

    lcd_char_queue #(.DEPTH(DEPTH), .AW(AW), .INIT_EN(1)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clk_en    (clk_en),
        .start     (start),
        .dataa     (dataa),
        .datab     (datab),
        .result    (result),
        .done      (done),
        .drv_start (drv_start),
        .drv_rs    (drv_rs),
        .drv_db    (drv_db),
        .drv_done  (drv_done)
    );

    always #10 clk = ~clk;

    // Byte driver model, reset by the same net as the DUT
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmr      <= 0;
            drv_done <= 1'b0;
        end else begin
            drv_done <= 1'b0;
            if (drv_start) begin
                tmr <= 20;
            end else if (tmr != 0) begin
                tmr <= tmr - 1;
                if (tmr == 1) drv_done <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (drv_done) dd_cnt <= dd_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (ci_q.size() == 0) begin
                check("ci_unexpected_done", 32'd1, 32'd0);
            end else begin
                ci_e = ci_q.pop_front();
                check("ci_accepted",  32'(result[0]),    32'(ci_e.acc));
                check("ci_count",     32'(result[12:8]), 32'(ci_e.cnt));
                check("ci_busy",      32'(result[16]),   32'(ci_e.busy));
                check("ci_init_done", 32'(result[17]),   32'(ci_e.init));
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && drv_start) begin
            if (drv_q.size() == 0) begin
                check("drv_unexpected_start", {23'd0, drv_rs, drv_db}, 32'h1ff);
            end else begin
                drv_e = drv_q.pop_front();
                check("drv_byte", {23'd0, drv_rs, drv_db}, {23'd0, drv_e});
            end
        end
    end

    task automatic ci_op(input logic [31:0] a, input logic [7:0] b, input logic acc,
                         input int cnt, input logic busy, input logic init);
        ci_exp_t e;
        e.acc  = acc;
        e.cnt  = (AW+1)'(cnt);
        e.busy = busy;
        e.init = init;
        ci_q.push_back(e);
        start = 1'b1;
        dataa = a;
        datab = {24'd0, b};
        @(negedge clk);
        start = 1'b0;
        dataa = '0;
        datab = '0;
    endtask

    task automatic exp_drv(input logic rs, input logic [7:0] b);
        drv_q.push_back({rs, b});
    endtask

    task automatic exp_init();
        exp_drv(1'b0, 8'h38);
        exp_drv(1'b0, 8'h0C);
        exp_drv(1'b0, 8'h01);
        exp_drv(1'b0, 8'h06);
    endtask

    task automatic wait_dd(input int target, input int budget);
        for (int i = 0; i < budget && dd_cnt < target; i++) @(negedge clk);
        check("drv_done_reached", 32'(dd_cnt >= target), 32'd1);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        #1;
        check("rst_drv_start", 32'(drv_start), 32'd0);
        check("rst_done",      32'(done),      32'd0);
        check("rst_result",    result,         32'd0);
        check("rst_drv_db",    32'(drv_db),    32'd0);
        check("rst_drv_rs",    32'(drv_rs),    32'd0);
        ci_q.delete();
        drv_q.delete();
        exp_init();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Power-up: init sequence with no pushes
        @(negedge clk);
        do_reset();
        base = dd_cnt;
        ci_op(32'h100, 8'h00, 1'b0, 0, 1'b1, 1'b0);
        wait_dd(base + 4, 200);
        repeat (3) @(negedge clk);
        ci_op(32'h100, 8'h00, 1'b0, 0, 1'b0, 1'b1);
        check("init_drained", 32'(drv_q.size()), 32'd0);

        // Back-to-back pushes; the second coincides with the pop of the first
        base = dd_cnt;
        exp_drv(1'b1, 8'h48);
        exp_drv(1'b1, 8'h69);
        exp_drv(1'b1, 8'h21);
        ci_op(32'h1, 8'h48, 1'b1, 1, 1'b1, 1'b1);
        ci_op(32'h1, 8'h69, 1'b1, 1, 1'b1, 1'b1);
        ci_op(32'h1, 8'h21, 1'b1, 2, 1'b1, 1'b1);
        wait_dd(base + 3, 200);
        repeat (3) @(negedge clk);
        ci_op(32'h100, 8'h00, 1'b0, 0, 1'b0, 1'b1);

        // Overfill during init: 17th push is dropped
        do_reset();
        base = dd_cnt;
        for (int i = 0; i < 17; i++) begin
            logic [7:0] b;
            b = 8'h30 + 8'(i);
            if (i < 16) exp_drv(i[0], b);
            ci_op({31'd0, i[0]}, b, (i < 16), (i < 16) ? i + 1 : 16, 1'b1, 1'b0);
        end
        wait_dd(base + 20, 800);
        repeat (3) @(negedge clk);
        check("fill_drained", 32'(drv_q.size()), 32'd0);

        // Pointer wrap: 40 pushes, each paced to the previous completion
        base = dd_cnt;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] b;
            b = 8'h40 + 8'(i);
            exp_drv(~i[0], b);
            ci_op({31'd0, ~i[0]}, b, 1'b1, 1, 1'b1, 1'b1);
            wait_dd(base + i + 1, 100);
        end
        repeat (3) @(negedge clk);
        check("wrap_drained", 32'(drv_q.size()), 32'd0);

        // Flush with one byte in flight and five queued; flush beats a push request
        base = dd_cnt;
        exp_drv(1'b0, 8'h50);
        ci_op(32'h0, 8'h50, 1'b1, 1, 1'b1, 1'b1);
        ci_op(32'h0, 8'h51, 1'b1, 1, 1'b1, 1'b1);
        ci_op(32'h0, 8'h52, 1'b1, 2, 1'b1, 1'b1);
        ci_op(32'h0, 8'h53, 1'b1, 3, 1'b1, 1'b1);
        ci_op(32'h0, 8'h54, 1'b1, 4, 1'b1, 1'b1);
        ci_op(32'h0, 8'h55, 1'b1, 5, 1'b1, 1'b1);
        ci_op(32'h100, 8'h56, 1'b0, 5, 1'b1, 1'b1);
        ci_op(32'h201, 8'h77, 1'b0, 0, 1'b1, 1'b1);
        wait_dd(base + 1, 100);
        repeat (40) @(negedge clk);
        check("flush_one_done", 32'(dd_cnt), 32'(base + 1));
        ci_op(32'h100, 8'h00, 1'b0, 0, 1'b0, 1'b1);
        check("flush_drained", 32'(drv_q.size()), 32'd0);

        // Reset while a byte is in flight
        exp_drv(1'b1, 8'h5A);
        ci_op(32'h1, 8'h5A, 1'b1, 1, 1'b1, 1'b1);
        repeat (6) @(negedge clk);
        check("mid_wait_queue", 32'(drv_q.size()), 32'd0);
        do_reset();
        base = dd_cnt;
        ci_op(32'h100, 8'h00, 1'b0, 0, 1'b1, 1'b0);
        wait_dd(base + 4, 200);
        repeat (3) @(negedge clk);
        ci_op(32'h100, 8'h00, 1'b0, 0, 1'b0, 1'b1);
        check("reinit_drained", 32'(drv_q.size()), 32'd0);

        repeat (2) @(negedge clk);
        check("ci_all_done", 32'(ci_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
